// File: rtl/soc_io.sv
// Memory-mapped IO page: LED register, UART transmitter, free-running cycle counter.
// Define SOC_IO_UART_EN to build the UART; without it TXD idles high and register 1 is inert.
module soc_io #(
  parameter int LED_W    = 5,
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200,
  parameter int IO_BIT   = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wmask,
  input  logic             mem_rstrb,
  output logic [31:0]      mem_rdata,
  output logic [LED_W-1:0] LEDS,
  output logic             TXD
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int DIV_W = (DIV < 2) ? 1 : $clog2(DIV);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("soc_io: CLK_FREQ/BAUD must be at least 2");
    end
    if (LED_W < 1 || LED_W > 32) begin : g_bad_led
      $error("soc_io: LED_W must be within 1..32");
    end
  endgenerate

  logic             w_sel;
  logic             w_wr;
  logic             w_rd;
  logic [1:0]       w_reg;
  logic [31:0]      w_ledOld;
  logic [31:0]      w_ledNew;
  logic [31:0]      w_rdMux;
  logic             w_busy;
  logic             w_overrun;
  logic             w_unused;
  logic [LED_W-1:0] r_led;
  logic [31:0]      r_rdata;
  logic [31:0]      r_cycle;

  assign w_sel    = mem_addr[IO_BIT];
  assign w_reg    = mem_addr[3:2];
  assign w_wr     = w_sel & (|mem_wmask);
  assign w_rd     = w_sel & mem_rstrb;
  assign w_unused = &{1'b0, mem_addr, w_ledNew};

  assign mem_rdata = r_rdata;
  assign LEDS      = r_led;

  // LED write is merged lane by lane over the zero-extended current value
  always_comb begin
    w_ledOld = 32'(r_led);
    w_ledNew = w_ledOld;
    for (int i = 0; i < 4; i++) begin
      if (mem_wmask[i]) w_ledNew[8*i +: 8] = mem_wdata[8*i +: 8];
    end
  end

  always_comb begin
    w_rdMux = '0;
    case (w_reg)
      2'd0:    w_rdMux = w_ledOld;
      2'd2:    w_rdMux = {30'd0, w_overrun, w_busy};
      2'd3:    w_rdMux = r_cycle;
      default: w_rdMux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led   <= '0;
      r_rdata <= '0;
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_rd) r_rdata <= w_rdMux;
      if (w_wr && (w_reg == 2'd0)) r_led <= w_ledNew[LED_W-1:0];
    end
  end

`ifdef SOC_IO_UART_EN
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  uart_state_t      r_state;
  uart_state_t      w_next;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_overrun;
  logic             w_dataWr;
  logic             w_accept;
  logic             w_statRd;
  logic             w_tick;
  logic             w_txd;

  assign w_dataWr  = w_wr & (w_reg == 2'd1);
  assign w_accept  = w_dataWr & mem_wmask[0] & (r_state == IDLE);
  assign w_statRd  = w_rd & (w_reg == 2'd2);
  assign w_tick    = (r_div == DIV_W'(DIV - 1));
  assign w_busy    = (r_state != IDLE);
  assign w_overrun = r_overrun;
  assign TXD       = w_txd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_txd  = 1'b1;
    case (r_state)
      IDLE:  if (w_accept) w_next = START;
      START: begin
        w_txd = 1'b0;
        if (w_tick) w_next = DATA;
      end
      DATA: begin
        w_txd = r_shift[0];
        if (w_tick && (r_bit == 3'd7)) w_next = STOP;
      end
      STOP:    if (w_tick) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A write while busy is dropped; overrun set beats the clearing status read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_div <= '0;
        r_bit <= '0;
        if (w_accept) r_shift <= mem_wdata[7:0];
      end else begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
        if ((r_state == DATA) && w_tick) begin
          r_shift <= {1'b0, r_shift[7:1]};
          r_bit   <= r_bit + 3'd1;
        end
      end
      if (w_dataWr && w_busy) r_overrun <= 1'b1;
      else if (w_statRd)      r_overrun <= 1'b0;
    end
  end
`else
  assign w_busy    = 1'b0;
  assign w_overrun = 1'b0;
  assign TXD       = 1'b1;
`endif

endmodule

// File: tb/tb_soc_io.sv
// Scoreboard bench for soc_io: stimulus pushes expected read data and TXD bits,
// a monitor pops and compares them as the DUT produces them.
module tb_soc_io;

  typedef struct {
    string       label;
    logic [31:0] value;
    bit          check;
  } rdExp_t;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic [4:0]  LEDS;
  logic        TXD;

  int          vectors;
  int          miscompares;
  rdExp_t      rdQ[$];
  bit          txQ[$];
  logic [31:0] tbCycles;
  logic [31:0] cntA;
  logic [31:0] cntB;
  logic        monRdSeen;
  rdExp_t      monExp;
  bit          monTx;

  soc_io #(.LED_W(5), .CLK_FREQ(16), .BAUD(4), .IO_BIT(22)) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata),
    .LEDS     (LEDS),
    .TXD      (TXD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count: edges seen since reset was released
  always @(posedge clk or negedge reset) begin
    if (!reset) tbCycles <= '0;
    else        tbCycles <= tbCycles + 32'd1;
  end

  always @(posedge clk) begin
    monRdSeen = reset && mem_rstrb && mem_addr[22];
    #1;
    if (monRdSeen) begin
      if (rdQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL rd_unexpected: got 0x%08h, no read was expected", mem_rdata);
      end else begin
        monExp = rdQ.pop_front();
        if (monExp.check) begin
          vectors++;
          if (mem_rdata !== monExp.value) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", monExp.label, mem_rdata, monExp.value);
          end
        end
      end
    end
    if (txQ.size() > 0) begin
      monTx = txQ.pop_front();
      vectors++;
      if (TXD !== monTx) begin
        miscompares++;
        $display("[TB] FAIL txd at %0t: got %b, expected %b", $time, TXD, monTx);
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wmask, input logic rstrb);
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wmask = wmask;
    mem_rstrb = rstrb;
    @(negedge clk);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    mem_rstrb = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pushRead(input string label, input logic [31:0] value, input bit check);
    rdExp_t e;
    e.label = label;
    e.value = value;
    e.check = check;
    rdQ.push_back(e);
  endtask

  task automatic pushIdleTx(input int n);
    for (int i = 0; i < n; i++) txQ.push_back(1'b1);
  endtask

  task automatic pushFrame(input logic [7:0] b);
    for (int i = 0; i < 4; i++) txQ.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < 4; i++) txQ.push_back(b[k]);
    pushIdleTx(5);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wmask   = '0;
    mem_rstrb   = 1'b0;
    idle(2);
    checkOutput("rst_leds", 32'(LEDS), 32'h0);
    checkOutput("rst_txd", 32'(TXD), 32'h1);
    checkOutput("rst_rdata", mem_rdata, 32'h0);
    reset = 1'b1;

    applyStimulus(32'h0040_0000, 32'h0000_00FF, 4'h1, 1'b0);
    checkOutput("led_wr", 32'(LEDS), 32'h1F);
    pushRead("led_rd", 32'h1F, 1'b1);
    applyStimulus(32'h0040_0000, 32'h0, 4'h0, 1'b1);
    idle(2);
    checkOutput("rdata_hold", mem_rdata, 32'h1F);
    applyStimulus(32'h0040_0000, 32'h0000_0000, 4'h2, 1'b0);
    checkOutput("led_lane1_only", 32'(LEDS), 32'h1F);
    applyStimulus(32'h0040_0000, 32'hFFFF_FF0A, 4'h1, 1'b0);
    checkOutput("led_lane0", 32'(LEDS), 32'h0A);
    applyStimulus(32'h0040_0000, 32'h1234_5600, 4'hE, 1'b0);
    checkOutput("led_upper_lanes", 32'(LEDS), 32'h0A);
    pushRead("rw_same_cycle", 32'h0A, 1'b1);
    applyStimulus(32'h0040_0000, 32'h0000_0015, 4'h1, 1'b1);
    checkOutput("rw_led", 32'(LEDS), 32'h15);
    pushRead("uart_data_rd", 32'h0, 1'b1);
    applyStimulus(32'h0040_0004, 32'h0, 4'h0, 1'b1);
    pushRead("led_rd2", 32'h15, 1'b1);
    applyStimulus(32'h0040_0000, 32'h0, 4'h0, 1'b1);

    applyStimulus(32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 1'b0);
    checkOutput("nonio_led", 32'(LEDS), 32'h15);
    applyStimulus(32'h0000_0000, 32'h0, 4'h0, 1'b1);
    checkOutput("nonio_rdata", mem_rdata, 32'h15);
    pushIdleTx(12);
    applyStimulus(32'h0000_0004, 32'h0000_00A5, 4'h1, 1'b0);
    pushRead("nonio_status", 32'h0, 1'b1);
    applyStimulus(32'h0040_0008, 32'h0, 4'h0, 1'b1);
    idle(12);
    applyStimulus(32'h8040_0010, 32'h0000_0003, 4'h1, 1'b0);
    checkOutput("led_alias", 32'(LEDS), 32'h03);

    pushRead("cnt_abs", tbCycles, 1'b1);
    applyStimulus(32'h0040_000C, 32'h0, 4'h0, 1'b1);
    pushRead("cnt_a", 32'h0, 1'b0);
    applyStimulus(32'h0040_000C, 32'h0, 4'h0, 1'b1);
    cntA = mem_rdata;
    idle(6);
    pushRead("cnt_b", 32'h0, 1'b0);
    applyStimulus(32'h0040_000C, 32'h0, 4'h0, 1'b1);
    checkOutput("cnt_diff", mem_rdata - cntA, 32'd7);

`ifdef SOC_IO_UART_EN
    pushFrame(8'hA5);
    applyStimulus(32'h0040_0004, 32'h0000_00A5, 4'h1, 1'b0);
    pushRead("busy_start", 32'h1, 1'b1);
    applyStimulus(32'h0040_0008, 32'h0, 4'h0, 1'b1);
    idle(38);
    pushRead("busy_last", 32'h1, 1'b1);
    applyStimulus(32'h0040_0008, 32'h0, 4'h0, 1'b1);
    pushRead("busy_done", 32'h0, 1'b1);
    applyStimulus(32'h0040_0008, 32'h0, 4'h0, 1'b1);
    idle(2);

    pushFrame(8'h3C);
    applyStimulus(32'h0040_0004, 32'h0000_003C, 4'h1, 1'b0);
    idle(4);
    applyStimulus(32'h0040_0004, 32'h0000_0055, 4'h1, 1'b0);
    pushRead("overrun_set", 32'h3, 1'b1);
    applyStimulus(32'h0040_0008, 32'h0, 4'h0, 1'b1);
    pushRead("overrun_clr", 32'h1, 1'b1);
    applyStimulus(32'h0040_0008, 32'h0, 4'h0, 1'b1);
    idle(34);
    pushRead("overrun_idle", 32'h0, 1'b1);
    applyStimulus(32'h0040_0008, 32'h0, 4'h0, 1'b1);
    idle(2);

    pushIdleTx(4);
    applyStimulus(32'h0040_0004, 32'h0000_00FF, 4'h2, 1'b0);
    pushRead("no_lane0_status", 32'h0, 1'b1);
    applyStimulus(32'h0040_0008, 32'h0, 4'h0, 1'b1);
    idle(4);
`else
    pushIdleTx(12);
    applyStimulus(32'h0040_0004, 32'h0000_00A5, 4'h1, 1'b0);
    pushRead("off_status", 32'h0, 1'b1);
    applyStimulus(32'h0040_0008, 32'h0, 4'h0, 1'b1);
    idle(12);
`endif

    force dut.r_cycle = 32'hFFFF_FFFC;
    idle(2);
    release dut.r_cycle;
    pushRead("wrap_a", 32'h0, 1'b0);
    applyStimulus(32'h0040_000C, 32'h0, 4'h0, 1'b1);
    cntA = mem_rdata;
    idle(5);
    pushRead("wrap_b", 32'h0, 1'b0);
    applyStimulus(32'h0040_000C, 32'h0, 4'h0, 1'b1);
    cntB = mem_rdata;
    checkOutput("wrap_a_high", 32'(cntA >= 32'hFFFF_FFF0), 32'h1);
    checkOutput("wrap_b_low", 32'(cntB < 32'h0000_0010), 32'h1);
    checkOutput("wrap_diff", cntB - cntA, 32'd6);

`ifdef SOC_IO_UART_EN
    txQ.push_back(1'b0); txQ.push_back(1'b0); txQ.push_back(1'b0); txQ.push_back(1'b0);
    txQ.push_back(1'b1); txQ.push_back(1'b1); txQ.push_back(1'b1); txQ.push_back(1'b1);
    txQ.push_back(1'b0); txQ.push_back(1'b0);
    applyStimulus(32'h0040_0004, 32'h0000_00A5, 4'h1, 1'b0);
    idle(9);
    checkOutput("pre_rst_txd", 32'(TXD), 32'h0);
`else
    applyStimulus(32'h0040_0000, 32'h0000_001F, 4'h1, 1'b0);
    idle(9);
`endif
    reset = 1'b0;
    #1;
    checkOutput("midrst_txd", 32'(TXD), 32'h1);
    checkOutput("midrst_leds", 32'(LEDS), 32'h0);
    checkOutput("midrst_rdata", mem_rdata, 32'h0);
    idle(3);
    reset = 1'b1;
    pushIdleTx(45);
    pushRead("cnt_after_rst", tbCycles, 1'b1);
    applyStimulus(32'h0040_000C, 32'h0, 4'h0, 1'b1);
    pushRead("status_after_rst", 32'h0, 1'b1);
    applyStimulus(32'h0040_0008, 32'h0, 4'h0, 1'b1);
    pushRead("led_after_rst", 32'h0, 1'b1);
    applyStimulus(32'h0040_0000, 32'h0, 4'h0, 1'b1);

    for (int i = 0; i < 100 && (txQ.size() > 0 || rdQ.size() > 0); i++) @(negedge clk);
    if (txQ.size() > 0 || rdQ.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL queue_drain: got %0d tx and %0d rd pending, expected 0", txQ.size(), rdQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
